mips_instr_encoder: RTL and testbench
=====================================

Name: mips_instr_encoder

Overview:
- Inverse of the team's control decoder: turns instruction fields into 32-bit MIPS words for the R-type, lw, sw and beq classes the decoder understands, plus nop.
- Accepts field bundles on a valid/ready input and buffers encoded words in a small FIFO.
- Streams each word with an instruction-memory word address on a valid/ready output.
- Used by the program loader and by benches to fill instruction memory feeding the decoder.

Parameters:
- DEPTH, 4, output FIFO entries (power of two, >=2).
- ADDR_W, 10, width of the instruction-memory word-address counter.
- BASE_ADDR, 0, word address assigned to the first instruction after reset.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  field bundle present.
- in_ready  output  1  block can accept a bundle this cycle.
- in_op  input  3  class: 000 R-type, 001 lw, 010 sw, 011 beq, 100 nop, 101-111 illegal.
- in_rs  input  5  rs field.
- in_rt  input  5  rt field.
- in_rd  input  5  rd field (R-type only).
- in_shamt  input  5  shamt field (R-type only).
- in_funct  input  6  funct field (R-type only).
- in_imm  input  16  immediate or branch offset (lw/sw/beq).
- out_valid  output  1  encoded word available.
- out_ready  input  1  consumer takes the word.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_W  word address of out_instr.
- err  output  1  one-cycle pulse when an illegal bundle is consumed.
- err_count  output  8  illegal bundles seen, saturates at 255.
- level  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst high at a clk edge): FIFO empty, write address = BASE_ADDR, err=0, err_count=0. Therefore out_valid=0, level=0, in_ready=1.
  - out_instr and out_addr read 0 after reset.
  - Reset mid-stream discards all queued words. No word is emitted on the cycle rst is high.
- Handshakes:
  - Input accept = in_valid && in_ready. Output pop = out_valid && out_ready.
  - in_ready = (level < DEPTH), registered-state based. There is no combinational path from out_ready, so a full FIFO refuses input even while popping that cycle.
  - out_valid = (level != 0). out_instr and out_addr come from the head entry and hold stable while out_valid && !out_ready.
- Latency: a word accepted at edge N is visible at out_valid/out_instr after edge N, i.e. one cycle. There is no combinational input-to-output bypass.
- Encoding (opcode[31:26]):
  - R-type: {000000, rs, rt, rd, shamt, funct}.
  - lw: {100011, rs, rt, imm}.
  - sw: {101011, rs, rt, imm}.
  - beq: {000100, rs, rt, imm}; imm is the caller-supplied word offset, passed through unchanged.
  - nop: 32'h0000_0000.
  - Fields not used by a class are ignored.
- Address counter:
  - Each accepted legal bundle (including nop) is tagged with the current address.
  - The counter then increments by 1 modulo 2^ADDR_W, wrapping with no flag.
- Illegal op (101-111):
  - The bundle is accepted (consumed when in_ready=1) but not queued; the address is not incremented.
  - err pulses high for exactly the cycle after acceptance.
  - err_count increments, holding at 255.
- Simultaneous push and pop at 0 < level < DEPTH: level is unchanged and ordering is preserved (strict FIFO).
- Pointer wrap: read/write pointers wrap modulo DEPTH. Full and empty are distinguished by level.
- Popping when empty or pushing when full is impossible by construction; those states must not corrupt the pointers.

Test Plan:
- R add $3,$1,$2 (op=000, rs=1, rt=2, rd=3, shamt=0, funct=0x20) with out_ready=1 -> one cycle later out_instr=0x00221820, out_addr=0, level=1.
- lw $8,4($29) then sw $8,-4($29) (rs=29, rt=8, imm=0x0004 / 0xFFFC), back-to-back -> 0x8FA80004 @ addr 0 then 0xAFA8FFFC @ addr 1, in order.
- beq $1,$2,+3 (imm=0x0003) and nop -> 0x10220003 @ addr 0, 0x00000000 @ addr 1.
- out_ready=0 while pushing 5 bundles with DEPTH=4 -> in_ready drops after the 4th accept and level=4; the 5th is held. Raise out_ready -> all 5 words drain in order with addrs 0-4, and out_instr stays stable while stalled.
- Illegal op=110 between two lw bundles -> err high exactly 1 cycle, err_count=1, only 2 words emitted with addrs 0,1. Send 300 illegal bundles -> err_count=255.
- ADDR_W=2: send 5 lw bundles -> addrs 0,1,2,3,0. Assert rst with 2 words queued -> out_valid=0, level=0 next cycle, and the next word gets addr BASE_ADDR.

Source files
------------

// File: rtl/mips_instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_instr_encoder_if
//  Description : Field-bundle input stream and encoded-word output stream
//                of the MIPS instruction encoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface mips_instr_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_op;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;

    // Producer of field bundles and consumer of encoded words
    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    // Encoder side
    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );
endinterface
`default_nettype wire

// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : mips_instr_encoder
//  Description : Encodes R-type / lw / sw / beq / nop field bundles into
//                32-bit MIPS words, tags each with an instruction-memory word
//                address and buffers them in a small FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_instr_encoder #(
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    mips_instr_encoder_if.slave          bus,
    output logic                         err,
    output logic [7:0]                   err_count,
    output logic [$clog2(DEPTH):0]       level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + 32;

    localparam logic [LVL_W-1:0]  c_FULL      = LVL_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] c_OP_RTYPE = 3'b000;
    localparam logic [2:0] c_OP_LW    = 3'b001;
    localparam logic [2:0] c_OP_SW    = 3'b010;
    localparam logic [2:0] c_OP_BEQ   = 3'b011;
    localparam logic [2:0] c_OP_NOP   = 3'b100;

    localparam logic [5:0] c_OPC_RTYPE = 6'b000000;
    localparam logic [5:0] c_OPC_LW    = 6'b100011;
    localparam logic [5:0] c_OPC_SW    = 6'b101011;
    localparam logic [5:0] c_OPC_BEQ   = 6'b000100;

    logic [ENT_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;
    logic [7:0]        r_err_cnt;

    logic [31:0]       w_instr;
    logic              w_legal;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic [ENT_W-1:0]  w_head;

    // Handshakes depend only on registered occupancy, never on out_ready
    assign bus.in_ready  = (r_level != c_FULL);
    assign bus.out_valid = (r_level != '0) && !rst;
    assign w_accept      = bus.in_valid && bus.in_ready;
    assign w_push        = w_accept && w_legal;
    assign w_pop         = bus.out_valid && bus.out_ready;

    // Head entry drives the output; data reads zero whenever nothing is valid
    assign w_head        = r_mem[r_rptr];
    assign bus.out_instr = bus.out_valid ? w_head[31:0] : 32'h0;
    assign bus.out_addr  = bus.out_valid ? w_head[ENT_W-1:32] : '0;

    assign level     = r_level;
    assign err       = r_err;
    assign err_count = r_err_cnt;

    // Field-to-word encoder; unused fields of a class are dropped
    always_comb begin
        w_instr = 32'h0;
        w_legal = 1'b1;
        case (bus.in_op)
            c_OP_RTYPE: w_instr = {c_OPC_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd,
                                   bus.in_shamt, bus.in_funct};
            c_OP_LW:    w_instr = {c_OPC_LW,  bus.in_rs, bus.in_rt, bus.in_imm};
            c_OP_SW:    w_instr = {c_OPC_SW,  bus.in_rs, bus.in_rt, bus.in_imm};
            c_OP_BEQ:   w_instr = {c_OPC_BEQ, bus.in_rs, bus.in_rt, bus.in_imm};
            c_OP_NOP:   w_instr = 32'h0;
            default:    w_legal = 1'b0;
        endcase
    end

    // FIFO storage: word plus its address, written at the tail
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_addr, w_instr};
        end
    end

    // Pointers, occupancy and address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_addr  <= c_BASE;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
                r_addr <= r_addr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Illegal-bundle pulse and saturating counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'h00;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_instr_encoder
//  Description : Directed self-checking bench. Instance A uses the default
//                parameters; instance B (ADDR_W=2, BASE_ADDR=1) sees the same
//                stimulus and exercises address wrap and the base address.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_instr_encoder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic        out_ready;

    logic        err_a, err_b;
    logic [7:0]  errc_a, errc_b;
    logic [2:0]  lvl_a, lvl_b;

    int checks   = 0;
    int failures = 0;

    mips_instr_encoder_if #(.ADDR_W(10)) ifa ();
    mips_instr_encoder_if #(.ADDR_W(2))  ifb ();

    assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
    assign ifa.in_op    = in_op;     assign ifb.in_op    = in_op;
    assign ifa.in_rs    = in_rs;     assign ifb.in_rs    = in_rs;
    assign ifa.in_rt    = in_rt;     assign ifb.in_rt    = in_rt;
    assign ifa.in_rd    = in_rd;     assign ifb.in_rd    = in_rd;
    assign ifa.in_shamt = in_shamt;  assign ifb.in_shamt = in_shamt;
    assign ifa.in_funct = in_funct;  assign ifb.in_funct = in_funct;
    assign ifa.in_imm   = in_imm;    assign ifb.in_imm   = in_imm;
    assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

    mips_instr_encoder #(.DEPTH(4), .ADDR_W(10), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave),
        .err(err_a), .err_count(errc_a), .level(lvl_a)
    );

    mips_instr_encoder #(.DEPTH(4), .ADDR_W(2), .BASE_ADDR(1)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave),
        .err(err_b), .err_count(errc_b), .level(lvl_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Head word and address on both instances; B's address is (k+1) mod 4
    task automatic chk_head(input string tag, input logic [31:0] instr, input int k);
        chk({tag, "_valid"}, 32'(ifa.out_valid), 32'd1);
        chk({tag, "_instr"}, ifa.out_instr, instr);
        chk({tag, "_addr_a"}, 32'(ifa.out_addr), 32'(k));
        chk({tag, "_instr_b"}, ifb.out_instr, instr);
        chk({tag, "_addr_b"}, 32'(ifb.out_addr), 32'((k + 1) % 4));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rs_v, input logic [4:0] rt_v,
                        input logic [4:0] rd_v, input logic [4:0] sh_v,
                        input logic [5:0] fn_v, input logic [15:0] imm_v);
        in_op = op; in_rs = rs_v; in_rt = rt_v; in_rd = rd_v;
        in_shamt = sh_v; in_funct = fn_v; in_imm = imm_v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 3'b000; in_rs = '0; in_rt = '0;
        in_rd = '0; in_shamt = '0; in_funct = '0; in_imm = '0; out_ready = 1'b0;
        #2;

        // ---- Reset state
        do_reset();
        chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_level", 32'(lvl_a), 32'd0);
        chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);
        chk("rst_out_instr", ifa.out_instr, 32'h0);
        chk("rst_out_addr", 32'(ifa.out_addr), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_err_count", 32'(errc_a), 32'd0);

        // ---- R-type add $3,$1,$2
        out_ready = 1'b1;
        send(3'b000, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hABCD);
        chk_head("radd", 32'h0022_1820, 0);
        chk("radd_level", 32'(lvl_a), 32'd1);
        tick();
        chk("radd_drained", 32'(ifa.out_valid), 32'd0);

        // ---- lw $8,4($29) then sw $8,-4($29) back to back
        do_reset();
        send(3'b001, 5'd29, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0004);
        chk_head("lw", 32'h8FA8_0004, 0);
        send(3'b010, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'hFFFC);
        chk_head("sw", 32'hAFA8_FFFC, 1);
        chk("sw_level", 32'(lvl_a), 32'd1);
        tick();

        // ---- beq $1,$2,+3 then nop with junk fields
        do_reset();
        send(3'b011, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0003);
        chk_head("beq", 32'h1022_0003, 0);
        send(3'b100, 5'd5, 5'd6, 5'd7, 5'd8, 6'h2A, 16'hFFFF);
        chk_head("nop", 32'h0000_0000, 1);
        tick();

        // ---- Backpressure: 5 bundles into a 4-deep FIFO
        do_reset();
        out_ready = 1'b0;
        in_op = 3'b001; in_rs = '0; in_rt = '0;
        for (int i = 0; i < 4; i++) begin
            in_imm = 16'(i);
            in_valid = 1'b1;
            tick();
        end
        chk("full_level", 32'(lvl_a), 32'd4);
        chk("full_in_ready", 32'(ifa.in_ready), 32'd0);
        in_imm = 16'd4;
        tick();
        tick();
        chk("stall_level", 32'(lvl_a), 32'd4);
        chk_head("stall", 32'h8C00_0000, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk_head("drain", 32'h8C00_0000 | 32'(k), k);
            tick();
            if (k == 1) begin
                in_valid = 1'b0;
            end
        end
        chk("drain_empty", 32'(lvl_a), 32'd0);
        chk("drain_empty_b", 32'(lvl_b), 32'd0);

        // ---- Illegal op between two lw bundles
        do_reset();
        send(3'b001, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0001);
        chk_head("ill_lw0", 32'h8C00_0001, 0);
        chk("ill_err_lo0", 32'(err_a), 32'd0);
        send(3'b110, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h1111);
        chk("ill_err_hi", 32'(err_a), 32'd1);
        chk("ill_err_b", 32'(err_b), 32'd1);
        chk("ill_errc", 32'(errc_a), 32'd1);
        chk("ill_not_queued", 32'(ifa.out_valid), 32'd0);
        send(3'b001, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0002);
        chk("ill_err_lo1", 32'(err_a), 32'd0);
        chk_head("ill_lw1", 32'h8C00_0002, 1);
        tick();
        chk("ill_two_only", 32'(ifa.out_valid), 32'd0);
        chk("ill_errc_hold", 32'(errc_a), 32'd1);

        // ---- 300 illegal bundles saturate the counter
        in_op = 3'b111;
        in_valid = 1'b1;
        repeat (300) tick();
        in_valid = 1'b0;
        chk("sat_errc", 32'(errc_a), 32'd255);
        chk("sat_errc_b", 32'(errc_b), 32'd255);
        chk("sat_level", 32'(lvl_a), 32'd0);
        tick();
        chk("sat_err_lo", 32'(err_a), 32'd0);

        // ---- Address wrap on B (ADDR_W=2) across 5 lw bundles
        do_reset();
        for (int k = 0; k < 5; k++) begin
            send(3'b001, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'(16 + k));
            chk_head("wrap", 32'h8C43_0010 + 32'(k), k);
        end
        tick();

        // ---- Reset with two words queued
        out_ready = 1'b0;
        send(3'b001, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0007);
        send(3'b001, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0008);
        chk("preq_level", 32'(lvl_a), 32'd2);
        rst = 1'b1;
        #1;
        chk("rstcyc_out_valid", 32'(ifa.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("midrst_level", 32'(lvl_a), 32'd0);
        chk("midrst_level_b", 32'(lvl_b), 32'd0);
        chk("midrst_in_ready", 32'(ifa.in_ready), 32'd1);
        out_ready = 1'b1;
        send(3'b001, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0009);
        chk_head("postrst", 32'h8C00_0009, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
